// File: rtl/restoring_divider_if.sv
// Operand/result bundle for the restoring divider.
// The master drives the operands and the slave returns the results.
interface restoring_divider_if #(
    parameter int SIZE = 16
);
    logic            Start;
    logic [SIZE-1:0] Dividend;
    logic [SIZE-1:0] Divisor;
    logic [SIZE-1:0] Quotient;
    logic [SIZE-1:0] Remainder;
    logic            Busy;
    logic            Done;
    logic            DivByZero;

    modport master (
        output Start, Dividend, Divisor,
        input  Quotient, Remainder, Busy, Done, DivByZero
    );

    modport slave (
        input  Start, Dividend, Divisor,
        output Quotient, Remainder, Busy, Done, DivByZero
    );
endinterface

// File: rtl/restoring_divider.sv
// Unsigned multi-cycle restoring divider, producing one quotient bit per clock.
// A zero divisor completes immediately with an all-ones quotient and the dividend as the remainder.
module restoring_divider #(
    parameter int SIZE = 16
) (
    input  logic               Clock,
    input  logic               Reset,
    restoring_divider_if.slave bus
);
    localparam int CW = $clog2(SIZE + 1);
    localparam logic [CW-1:0] COUNT_INIT = CW'(SIZE);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t          r_state, w_state_next;
    logic [CW-1:0]   r_count, w_count_next;
    logic [SIZE-1:0] r_rem, w_rem_next;
    logic [SIZE-1:0] r_quo, w_quo_next;
    logic [SIZE-1:0] r_divisor, w_divisor_next;
    logic [SIZE-1:0] r_quotient, w_quotient_next;
    logic [SIZE-1:0] r_remainder, w_remainder_next;
    logic            r_done, w_done_next;
    logic            r_dbz, w_dbz_next;

    // r_quo starts out holding the dividend; its bits shift out into the
    // partial remainder while quotient bits shift in from the bottom.
    logic [SIZE:0]   w_shift;
    logic [SIZE:0]   w_trial;
    logic [SIZE-1:0] w_rem_step;
    logic [SIZE-1:0] w_quo_step;

    // One bit wider than the operands so a divisor with its MSB set cannot overflow.
    assign w_shift    = {r_rem, r_quo[SIZE-1]};
    assign w_trial    = w_shift - {1'b0, r_divisor};
    assign w_rem_step = w_trial[SIZE] ? w_shift[SIZE-1:0] : w_trial[SIZE-1:0];
    assign w_quo_step = {r_quo[SIZE-2:0], ~w_trial[SIZE]};

    always_comb begin
        w_state_next     = r_state;
        w_count_next     = r_count;
        w_rem_next       = r_rem;
        w_quo_next       = r_quo;
        w_divisor_next   = r_divisor;
        w_quotient_next  = r_quotient;
        w_remainder_next = r_remainder;
        w_dbz_next       = r_dbz;
        w_done_next      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.Start) begin
                    if (bus.Divisor == '0) begin
                        w_state_next     = S_DONE;
                        w_quotient_next  = '1;
                        w_remainder_next = bus.Dividend;
                        w_dbz_next       = 1'b1;
                        w_done_next      = 1'b1;
                    end else begin
                        w_state_next   = S_RUN;
                        w_quo_next     = bus.Dividend;
                        w_divisor_next = bus.Divisor;
                        w_rem_next     = '0;
                        w_count_next   = COUNT_INIT;
                    end
                end
            end
            S_RUN: begin
                w_rem_next   = w_rem_step;
                w_quo_next   = w_quo_step;
                w_count_next = r_count - CW'(1);
                if (r_count == CW'(1)) begin
                    w_state_next     = S_DONE;
                    w_quotient_next  = w_quo_step;
                    w_remainder_next = w_rem_step;
                    w_dbz_next       = 1'b0;
                    w_done_next      = 1'b1;
                end
            end
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_state     <= S_IDLE;
            r_count     <= '0;
            r_rem       <= '0;
            r_quo       <= '0;
            r_divisor   <= '0;
            r_quotient  <= '0;
            r_remainder <= '0;
            r_done      <= 1'b0;
            r_dbz       <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_count     <= w_count_next;
            r_rem       <= w_rem_next;
            r_quo       <= w_quo_next;
            r_divisor   <= w_divisor_next;
            r_quotient  <= w_quotient_next;
            r_remainder <= w_remainder_next;
            r_done      <= w_done_next;
            r_dbz       <= w_dbz_next;
        end
    end

    assign bus.Quotient  = r_quotient;
    assign bus.Remainder = r_remainder;
    assign bus.Busy      = (r_state == S_RUN);
    assign bus.Done      = r_done;
    assign bus.DivByZero = r_dbz;
endmodule

// File: doc/restoring_divider.md
RESTORING_DIVIDER -- requirements
Module: restoring_divider

Interface
REQ-001 Parameter SIZE, default 16, SHALL set the operand, quotient and remainder width in bits (SIZE >= 2).
REQ-002 Clock  input  1  SHALL be the clock; all state changes occur on its rising edge.
REQ-003 Reset  input  1  SHALL be the reset: synchronous, active-high.
REQ-004 Start  input  1  SHALL request a division; it is sampled only in IDLE.
REQ-005 Dividend  input  SIZE  SHALL be the unsigned numerator, captured on the accepting edge.
REQ-006 Divisor  input  SIZE  SHALL be the unsigned denominator, captured on the accepting edge.
REQ-007 Quotient  output  SIZE  SHALL be the registered unsigned quotient of the last completed operation.
REQ-008 Remainder  output  SIZE  SHALL be the registered unsigned remainder of the last completed operation.
REQ-009 Busy  output  1  SHALL be high while an accepted operation is in progress (RUN state).
REQ-010 Done  output  1  SHALL be a registered one-cycle completion pulse.
REQ-011 DivByZero  output  1  SHALL flag that the last completed operation had Divisor == 0.

Function
REQ-012 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-013 IDLE with Start=1 and Divisor!=0: the block SHALL latch operands, load step counter = SIZE, clear the partial remainder, and go to RUN.
REQ-014 IDLE with Start=1 and Divisor==0: the block SHALL go directly to DONE, with Quotient = all ones, Remainder = Dividend, DivByZero = 1.
REQ-015 RUN, per edge: one restoring step SHALL run: shift {rem, dividend} left by 1, trial = rem - divisor (SIZE+1-bit); if trial >= 0, rem = trial and quotient LSB = 1, else rem is restored and quotient LSB = 0; counter decrements.
REQ-016 RUN with counter reaching 0 after the step: the block SHALL go to DONE and register Quotient/Remainder, with DivByZero = 0.
REQ-017 Latency SHALL be exactly SIZE edges from the Start-accepting edge until Done is visible (1 edge for divide-by-zero).
REQ-018 In DONE, Done=1 for exactly one cycle; the next edge SHALL return to IDLE unconditionally.
REQ-019 Start SHALL be ignored in RUN and DONE; no queuing, and in-flight operands are unaffected.
REQ-020 Quotient, Remainder and DivByZero SHALL hold their values until the next completion or Reset.
REQ-021 Dividend/Divisor changes after acceptance SHALL have no effect on the in-flight result.
REQ-022 Results SHALL satisfy Quotient*Divisor + Remainder == Dividend and Remainder < Divisor for every Divisor != 0.
REQ-023 Internal subtraction SHALL be SIZE+1 bits wide so that Divisor values with the MSB set never overflow.

Reset
REQ-024 Reset=1 at any edge SHALL force IDLE, counter=0, Quotient=0, Remainder=0, Busy=0, Done=0, DivByZero=0.
REQ-025 Reset SHALL take priority over Start and over an in-progress RUN; the aborted operation SHALL produce no Done.
REQ-026 Start asserted in the same cycle as Reset SHALL be ignored.

Verification
REQ-027 SIZE=16, Dividend=100, Divisor=7, Start for 1 cycle -> Busy=1 for 16 cycles; Done pulses 16 edges after acceptance; Quotient=14, Remainder=2, DivByZero=0.
REQ-028 Dividend=0xFFFF, Divisor=1 -> Quotient=0xFFFF, Remainder=0; Dividend=3, Divisor=10 -> Quotient=0, Remainder=3; Dividend=0xFFFF, Divisor=0x8000 -> Quotient=1, Remainder=0x7FFF.
REQ-029 Dividend=5, Divisor=0 -> Done 1 edge after acceptance; Quotient=0xFFFF, Remainder=5, DivByZero=1, Busy never high.
REQ-030 Start held high continuously with operands changed mid-RUN -> first result is unaffected; the second operation is accepted only on the edge after DONE returns to IDLE.
REQ-031 Reset asserted at the 8th RUN cycle -> next cycle all outputs are 0 and the state is IDLE; no Done appears; a subsequent 100/7 still yields 14 r 2.
REQ-032 Random sweep of 10k operand pairs -> every result matches the REQ-022 reference model, and Done is exactly one cycle wide every time.
